// File: rtl/multi_alarm_clock_core.sv
// Multi-alarm clock core: BCD time-of-day counter with a validated load
// path, NUM_ALARMS enable-gated alarm entries, a ring/snooze/dismiss state
// machine and 12/24-hour display conversion, all in a single clock domain.
module multi_alarm_clock_core #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int NUM_ALARMS    = 4,
  parameter int IDX_W         = 2,
  parameter int RING_SEC      = 60,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  input  logic [23:0]      set_time,
  input  logic             alm_wr,
  input  logic [IDX_W-1:0] alm_idx,
  input  logic [15:0]      alm_time,
  input  logic             alm_en,
  input  logic             snooze,
  input  logic             dismiss,
  input  logic             mode_12h,
  output logic [23:0]      time_bcd,
  output logic [23:0]      disp_bcd,
  output logic             pm,
  output logic             sec_pulse,
  output logic             ringing,
  output logic [IDX_W-1:0] ring_idx,
  output logic             set_err
);

  localparam int PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]         RING_LIM  = 8'(RING_SEC);
  localparam logic [9:0]         SNZ_LOAD  = 10'(SNOOZE_MIN * 60);
  // Widened by one bit so NUM_ALARMS itself is representable (e.g. 16).
  localparam logic [IDX_W:0]     ALM_COUNT = (IDX_W + 1)'(NUM_ALARMS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE
  } state_t;

  // Time-of-day and prescaler state
  logic [PRESC_W-1:0] presc_q;
  logic [23:0]        time_q;
  logic               sec_pulse_q;
  logic               set_err_q;

  // Alarm table
  logic [15:0]           alm_hm_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alm_en_q;

  // Alarm state machine
  state_t           state_q;
  logic             ringing_q;
  logic [IDX_W-1:0] ring_idx_q;
  logic [7:0]       ring_cnt_q;
  logic [9:0]       snz_cnt_q;

  // Hour field is 00..23 in BCD.
  function automatic logic hour_ok(input logic [7:0] h);
    return (h[7:4] <= 4'd1 && h[3:0] <= 4'd9) ||
           (h[7:4] == 4'd2 && h[3:0] <= 4'd3);
  endfunction

  // Minute or second field is 00..59 in BCD.
  function automatic logic min_ok(input logic [7:0] m);
    return (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9);
  endfunction

  // One-second BCD increment with carries through 23:59:59 -> 00:00:00.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] hs, hg, ms, mg, ss, sg;
    {hs, hg, ms, mg, ss, sg} = t;
    if (sg != 4'd9) begin
      sg = sg + 4'd1;
    end else begin
      sg = 4'd0;
      if (ss != 4'd5) begin
        ss = ss + 4'd1;
      end else begin
        ss = 4'd0;
        if (mg != 4'd9) begin
          mg = mg + 4'd1;
        end else begin
          mg = 4'd0;
          if (ms != 4'd5) begin
            ms = ms + 4'd1;
          end else begin
            ms = 4'd0;
            if (hs == 4'd2 && hg == 4'd3) begin
              hs = 4'd0;
              hg = 4'd0;
            end else if (hg != 4'd9) begin
              hg = hg + 4'd1;
            end else begin
              hg = 4'd0;
              hs = hs + 4'd1;
            end
          end
        end
      end
    end
    return {hs, hg, ms, mg, ss, sg};
  endfunction

  logic set_ok, alm_ok, set_load, alm_load, tick, disable_active;

  assign set_ok   = hour_ok(set_time[23:16]) && min_ok(set_time[15:8]) &&
                    min_ok(set_time[7:0]);
  assign alm_ok   = hour_ok(alm_time[15:8]) && min_ok(alm_time[7:0]) &&
                    ({1'b0, alm_idx} < ALM_COUNT);
  assign set_load = set_valid && set_ok;
  assign alm_load = alm_wr && alm_ok;
  assign tick     = (presc_q == PRESC_MAX);

  // Disabling the entry that is ringing or snoozed cancels the alarm.
  assign disable_active = alm_load && !alm_en && (alm_idx == ring_idx_q);

  // Prescaler, time register, second pulse and rejection pulse
  // NOTE: every clocked register uses non-blocking (<=) assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      time_q      <= '0;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      set_err_q <= (set_valid && !set_ok) || (alm_wr && !alm_ok);
      if (set_load) begin
        // A load overrides a coincident tick and restarts the second.
        time_q      <= set_time;
        presc_q     <= '0;
        sec_pulse_q <= 1'b0;
      end else if (tick) begin
        time_q      <= bcd_inc(time_q);
        presc_q     <= '0;
        sec_pulse_q <= 1'b1;
      end else begin
        presc_q     <= presc_q + 1'b1;
        sec_pulse_q <= 1'b0;
      end
    end
  end

  // Alarm table writes
  // NOTE: the alarm table is a handful of flops that must come up disabled,
  // so it is reset like any other register rather than treated as a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_hm_q[i] <= '0;
        alm_en_q[i] <= 1'b0;
      end
    end else if (alm_load) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alm_idx == IDX_W'(i)) begin
          alm_hm_q[i] <= alm_time;
          alm_en_q[i] <= alm_en;
        end
      end
    end
  end

  logic             match_hit;
  logic [IDX_W-1:0] match_idx;
  logic             alarm_trig;

  // Lowest-index enabled entry whose hh:mm equals the current time
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alm_en_q[i] && (alm_hm_q[i] == time_q[23:8])) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // sec_pulse only follows a real advance, so loads can never trigger.
  assign alarm_trig = sec_pulse_q && (time_q[7:0] == 8'h00) && match_hit;

  // Ring / snooze / dismiss state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ringing_q  <= 1'b0;
      ring_idx_q <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else if (set_load || disable_active) begin
      state_q   <= ST_IDLE;
      ringing_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_trig) begin
            state_q    <= ST_RING;
            ringing_q  <= 1'b1;
            ring_idx_q <= match_idx;
            ring_cnt_q <= '0;
          end
        end
        ST_RING: begin
          // Further matches are ignored while ringing.
          if (dismiss) begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
          end else if (snooze) begin
            state_q   <= ST_SNOOZE;
            ringing_q <= 1'b0;
            snz_cnt_q <= SNZ_LOAD;
          end else if (sec_pulse_q) begin
            if (ring_cnt_q + 8'd1 == RING_LIM) begin
              state_q   <= ST_IDLE;
              ringing_q <= 1'b0;
            end else begin
              ring_cnt_q <= ring_cnt_q + 8'd1;
            end
          end
        end
        ST_SNOOZE: begin
          if (dismiss) begin
            state_q <= ST_IDLE;
          end else if (alarm_trig) begin
            // A fresh match preempts the pending snooze.
            state_q    <= ST_RING;
            ringing_q  <= 1'b1;
            ring_idx_q <= match_idx;
            ring_cnt_q <= '0;
          end else if (sec_pulse_q) begin
            if (snz_cnt_q == 10'd1) begin
              state_q    <= ST_RING;
              ringing_q  <= 1'b1;
              ring_cnt_q <= '0;
            end else begin
              snz_cnt_q <= snz_cnt_q - 10'd1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ringing_q <= 1'b0;
        end
      endcase
    end
  end

  logic [7:0] hour;
  logic [7:0] disp_hour;

  assign hour = time_q[23:16];

  // 12-hour display conversion: 00 -> 12, 13..23 -> 01..11
  always_comb begin
    disp_hour = hour;
    if (mode_12h) begin
      if (hour == 8'h00) begin
        disp_hour = 8'h12;
      end else if (hour[7:4] == 4'd1 && hour[3:0] >= 4'd3) begin
        disp_hour = {4'd0, hour[3:0] - 4'd2};
      end else if (hour[7:4] == 4'd2 && hour[3:0] <= 4'd1) begin
        disp_hour = {4'd0, hour[3:0] + 4'd8};
      end else if (hour[7:4] == 4'd2) begin
        disp_hour = {4'd1, hour[3:0] - 4'd2};
      end
    end
  end

  assign pm        = (hour[7:4] == 4'd2) || (hour[7:4] == 4'd1 && hour[3:0] >= 4'd2);
  assign disp_bcd  = {disp_hour, time_q[15:0]};
  assign time_bcd  = time_q;
  assign sec_pulse = sec_pulse_q;
  assign ringing   = ringing_q;
  assign ring_idx  = ring_idx_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Directed self-checking bench for multi_alarm_clock_core with a 4-tick
// second, 4 alarms, 3-second ring and 1-minute snooze.
module tb_multi_alarm_clock_core;

  logic        clk;
  logic        rst;
  logic        set_valid;
  logic [23:0] set_time;
  logic        alm_wr;
  logic [1:0]  alm_idx;
  logic [15:0] alm_time;
  logic        alm_en;
  logic        snooze;
  logic        dismiss;
  logic        mode_12h;
  logic [23:0] time_bcd;
  logic [23:0] disp_bcd;
  logic        pm;
  logic        sec_pulse;
  logic        ringing;
  logic [1:0]  ring_idx;
  logic        set_err;

  int n_vec;
  int n_err;
  int pulse_cnt;
  bit ring_seen;

  multi_alarm_clock_core #(
    .TICKS_PER_SEC(4),
    .NUM_ALARMS   (4),
    .IDX_W        (2),
    .RING_SEC     (3),
    .SNOOZE_MIN   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_valid(set_valid),
    .set_time (set_time),
    .alm_wr   (alm_wr),
    .alm_idx  (alm_idx),
    .alm_time (alm_time),
    .alm_en   (alm_en),
    .snooze   (snooze),
    .dismiss  (dismiss),
    .mode_12h (mode_12h),
    .time_bcd (time_bcd),
    .disp_bcd (disp_bcd),
    .pm       (pm),
    .sec_pulse(sec_pulse),
    .ringing  (ringing),
    .ring_idx (ring_idx),
    .set_err  (set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sec_pulse) pulse_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_time(input logic [23:0] t);
    set_valid = 1'b1;
    set_time  = t;
    tick();
    set_valid = 1'b0;
  endtask

  task automatic write_alarm(input logic [1:0] idx, input logic [15:0] hm, input logic en);
    alm_wr   = 1'b1;
    alm_idx  = idx;
    alm_time = hm;
    alm_en   = en;
    tick();
    alm_wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; pulse_cnt = 0; ring_seen = 1'b0;
    rst = 1'b1; set_valid = 1'b0; set_time = '0; alm_wr = 1'b0; alm_idx = '0;
    alm_time = '0; alm_en = 1'b0; snooze = 1'b0; dismiss = 1'b0; mode_12h = 1'b0;

    // Reset state
    #12;
    check("rst_time", time_bcd, 24'h000000);
    check("rst_disp", disp_bcd, 24'h000000);
    check("rst_ringing", ringing, 0);
    check("rst_ring_idx", ring_idx, 0);
    check("rst_sec_pulse", sec_pulse, 0);
    check("rst_set_err", set_err, 0);
    rst = 1'b0;

    // Rollover through midnight
    load_time(24'h235958);
    check("roll_load", time_bcd, 24'h235958);
    check("roll_pm_before", pm, 1);
    pulse_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("roll_pulse_%0d", i), sec_pulse, (i == 4 || i == 8) ? 1 : 0);
      if (i == 4) check("roll_59", time_bcd, 24'h235959);
    end
    check("roll_midnight", time_bcd, 24'h000000);
    check("roll_pm_after", pm, 0);
    check("roll_pulse_count", pulse_cnt, 2);

    // Validation of loads and alarm writes
    load_time(24'h240000);
    check("bad_hour_err", set_err, 1);
    check("bad_hour_time", time_bcd, 24'h000000);
    check("midnight_no_ring", ringing, 0);
    tick();
    check("err_drops", set_err, 0);
    load_time(24'h126000);
    check("bad_min_err", set_err, 1);
    check("bad_min_time", time_bcd, 24'h000000);
    write_alarm(2'd3, 16'h127A, 1'b1);
    check("bad_alarm_err", set_err, 1);
    tick();
    check("err_drops2", set_err, 0);
    load_time(24'h123456);
    check("good_load", time_bcd, 24'h123456);
    check("good_load_err", set_err, 0);
    check("good_load_nopulse", sec_pulse, 0);
    write_alarm(2'd1, 16'h0700, 1'b1);
    check("alarm_wr_ok", set_err, 0);
    write_alarm(2'd2, 16'h0700, 1'b1);
    tick();
    check("presc_hold", time_bcd, 24'h123456);
    tick();
    check("presc_wrap_time", time_bcd, 24'h123457);
    check("presc_wrap_pulse", sec_pulse, 1);
    ticks(3);
    // Load lands exactly on a would-be tick edge
    load_time(24'h065959);
    check("set_wins_time", time_bcd, 24'h065959);
    check("set_wins_pulse", sec_pulse, 0);

    // Priority between alarms 1 and 2, then auto-stop
    ticks(4);
    check("prio_time", time_bcd, 24'h070000);
    check("prio_not_yet", ringing, 0);
    tick();
    check("prio_ringing", ringing, 1);
    check("prio_idx", ring_idx, 1);
    pulse_cnt = 0;
    ticks(11);
    check("auto_still_ringing", ringing, 1);
    check("auto_pulses", pulse_cnt, 3);
    tick();
    check("auto_stop", ringing, 0);
    check("idle_hold_idx", ring_idx, 1);

    // Snooze on alarm 0
    write_alarm(2'd0, 16'h0800, 1'b1);
    load_time(24'h075959);
    ticks(5);
    check("snz_ring", ringing, 1);
    check("snz_idx0", ring_idx, 0);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check("snz_quiet", ringing, 0);
    pulse_cnt = 0;
    for (int i = 0; i < 400 && !ringing; i++) tick();
    check("snz_pulses", pulse_cnt, 60);
    check("snz_rering", ringing, 1);
    check("snz_rering_idx", ring_idx, 0);
    check("snz_rering_time", time_bcd, 24'h080100);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    check("dismiss", ringing, 0);

    // Dismiss and snooze together: must end in IDLE, never re-ring
    load_time(24'h075959);
    ticks(5);
    check("coll_ring", ringing, 1);
    dismiss = 1'b1;
    snooze  = 1'b1;
    tick();
    dismiss = 1'b0;
    snooze  = 1'b0;
    check("coll_off", ringing, 0);
    ring_seen = 1'b0;
    for (int i = 0; i < 260; i++) begin
      tick();
      if (ringing) ring_seen = 1'b1;
    end
    check("coll_no_rering", ring_seen, 0);

    // New match during snooze preempts it
    write_alarm(2'd0, 16'h0900, 1'b1);
    write_alarm(2'd3, 16'h0901, 1'b1);
    load_time(24'h085959);
    ticks(5);
    check("pre_ring", ringing, 1);
    check("pre_idx", ring_idx, 0);
    pulse_cnt = 0;
    for (int i = 0; i < 20 && pulse_cnt < 2; i++) tick();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check("pre_snoozed", ringing, 0);
    for (int i = 0; i < 400 && !ringing; i++) tick();
    check("pre_rering", ringing, 1);
    check("pre_idx3", ring_idx, 3);
    check("pre_time", time_bcd, 24'h090100);

    // set_valid while ringing, then 12-hour conversion
    mode_12h = 1'b1;
    load_time(24'h130509);
    check("set_stops_ring", ringing, 0);
    check("set_keeps_idx", ring_idx, 3);
    check("h12_1305_disp", disp_bcd, 24'h010509);
    check("h12_1305_pm", pm, 1);
    load_time(24'h001500);
    check("h12_0015_disp", disp_bcd, 24'h121500);
    check("h12_0015_pm", pm, 0);
    load_time(24'h120000);
    check("h12_1200_disp", disp_bcd, 24'h120000);
    check("h12_1200_pm", pm, 1);
    load_time(24'h213000);
    check("h12_2130_disp", disp_bcd, 24'h093000);
    mode_12h = 1'b0;
    #1;
    check("h24_2130_disp", disp_bcd, 24'h213000);

    // Asynchronous reset in the middle of ringing
    load_time(24'h090059);
    ticks(5);
    check("mid_ring", ringing, 1);
    check("mid_idx", ring_idx, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_ringing", ringing, 0);
    check("arst_idx", ring_idx, 0);
    check("arst_time", time_bcd, 24'h000000);
    check("arst_disp", disp_bcd, 24'h000000);
    check("arst_pm", pm, 0);
    check("arst_pulse", sec_pulse, 0);
    check("arst_err", set_err, 0);
    #2 rst = 1'b0;

    // Alarm table cleared by reset: 09:01 no longer rings
    load_time(24'h090059);
    ticks(6);
    check("arst_table_cleared", ringing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
